lut_nco_quadrature: RTL and testbench

- Parametrised successor to the single-output LUT NCO.
- Phase accumulator with fractional bits drives a quarter-wave sine LUT and produces sine and cosine outputs. Adds a per-sample phase offset, a tuning-word load handshake with immediate or wrap-synchronised update, valid/wrap strobes, and a fixed 3-cycle output pipeline.
- Sits between the control register block (tuning word, offset, mode) and the DAC/mixer datapath.

---
 rtl/nco_pkg.sv | 36 +++
 rtl/nco_quarter_lut.sv | 38 +++
 rtl/lut_nco_quadrature.sv | 162 ++++++++++++++++
 tb/tb_lut_nco_quadrature.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: sizing helpers, mode encodings and quarter-wave table
// generator shared by the quadrature LUT NCO and its ROM.
package nco_pkg;

  localparam int DEF_LUT_LENGTH = 6;
  localparam int DEF_PHASE_FRAC = 8;
  localparam int PHASE_INT = DEF_LUT_LENGTH + 2;
  localparam int ACC_SIZE = PHASE_INT + DEF_PHASE_FRAC;

  localparam logic NCO_MODE_IMMEDIATE = 1'b0;
  localparam logic NCO_MODE_AT_WRAP = 1'b1;

  function automatic int phase_int_of(int lut_length);
    return lut_length + 2;
  endfunction

  function automatic int acc_size_of(int lut_length,
                                     int phase_frac);
    return phase_int_of(lut_length) + phase_frac;
  endfunction

  // Half-sample offset keeps the mirrored quadrants exact.
  function automatic logic [31:0] lut_value(int width,
                                            int length,
                                            int k);
    real amp;
    real ang;
    real x;
    amp = (2.0 ** (width - 1)) - 1.0;
    ang = 3.14159265358979 / 2.0
          * (real'(k) + 0.5) / (2.0 ** length);
    x = amp * $sin(ang);
    return 32'($rtoi(x + 0.5));
  endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: dual-read registered quarter-wave sine ROM.
// Ports: clk/reset/en, addr_a/addr_b in, data_a/data_b magnitudes out.
module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int LUT_WIDTH = 16,
  parameter int LUT_LENGTH = DEF_LUT_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [LUT_LENGTH-1:0] addr_a,
  input  logic [LUT_LENGTH-1:0] addr_b,
  output logic [LUT_WIDTH-1:0]  data_a,
  output logic [LUT_WIDTH-1:0]  data_b
);

  localparam int DEPTH = 1 << LUT_LENGTH;

  logic [LUT_WIDTH-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [31:0] V =
      lut_value(LUT_WIDTH, LUT_LENGTH, k);
    assign rom[k] = V[LUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/lut_nco_quadrature.sv
// lut_nco_quadrature: phase-accumulator NCO with sine/cosine outputs,
// phase offset, step load (immediate or at wrap), valid/wrap strobes.
// Ports: iclk, ireset, inCS (active-low enable), istep, istep_valid,
// imode, ioffset in; osin, ocos, ovalid, owrap out (3-stage latency).
module lut_nco_quadrature
  import nco_pkg::*;
#(
  parameter int LUT_WIDTH = 16,
  parameter int LUT_LENGTH = DEF_LUT_LENGTH,
  parameter int PHASE_FRAC = DEF_PHASE_FRAC
) (
  input  logic                             iclk,
  input  logic                             ireset,
  input  logic                             inCS,
  input  logic [LUT_LENGTH+PHASE_FRAC+1:0] istep,
  input  logic                             istep_valid,
  input  logic                             imode,
  input  logic [LUT_LENGTH+1:0]            ioffset,
  output logic [LUT_WIDTH-1:0]             osin,
  output logic [LUT_WIDTH-1:0]             ocos,
  output logic                             ovalid,
  output logic                             owrap
);

  localparam int PW = phase_int_of(LUT_LENGTH);
  localparam int AW = acc_size_of(LUT_LENGTH, PHASE_FRAC);
  localparam int LL = LUT_LENGTH;

  logic en;
  assign en = ~inCS;

  logic [AW-1:0] step_active;
  logic [AW-1:0] step_pending;
  logic [AW-1:0] acc;
  logic          acc_v;
  logic          acc_wrap;

  logic [AW:0] sum;
  logic        carry;
  assign sum = {1'b0, acc} + {1'b0, step_active};
  assign carry = sum[AW];

  always_ff @(posedge iclk) begin
    if (ireset) begin
      step_active <= '0;
      step_pending <= '0;
    end else begin
      if (istep_valid)
        step_pending <= istep;
      if (imode == NCO_MODE_IMMEDIATE) begin
        if (istep_valid)
          step_active <= istep;
      end else if (en && carry) begin
        step_active <= istep_valid ? istep : step_pending;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      acc <= '0;
      acc_v <= 1'b0;
      acc_wrap <= 1'b0;
    end else if (en) begin
      acc <= sum[AW-1:0];
      acc_v <= 1'b1;
      acc_wrap <= carry;
    end
  end

  // Stage 1: phase, quadrant fold and sign for both channels.
  logic [PW-1:0] p_sin;
  logic [PW-1:0] p_cos;
  logic [LL-1:0] a_sin;
  logic [LL-1:0] a_cos;

  assign p_sin = acc[AW-1:PHASE_FRAC] + ioffset;
  assign p_cos = p_sin + {2'b01, {LL{1'b0}}};
  assign a_sin = p_sin[PW-2] ? ~p_sin[LL-1:0]
                             : p_sin[LL-1:0];
  assign a_cos = p_cos[PW-2] ? ~p_cos[LL-1:0]
                             : p_cos[LL-1:0];

  logic [LL-1:0] s1_a_sin;
  logic [LL-1:0] s1_a_cos;
  logic          s1_neg_s;
  logic          s1_neg_c;
  logic          s1_v;
  logic          s1_wrap;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      s1_a_sin <= '0;
      s1_a_cos <= '0;
      s1_neg_s <= 1'b0;
      s1_neg_c <= 1'b0;
      s1_v <= 1'b0;
      s1_wrap <= 1'b0;
    end else if (en) begin
      s1_a_sin <= a_sin;
      s1_a_cos <= a_cos;
      s1_neg_s <= p_sin[PW-1];
      s1_neg_c <= p_cos[PW-1];
      s1_v <= acc_v;
      s1_wrap <= acc_wrap;
    end
  end

  // Stage 2: table read, flags travel alongside.
  logic [LUT_WIDTH-1:0] mag_s;
  logic [LUT_WIDTH-1:0] mag_c;
  logic                 s2_neg_s;
  logic                 s2_neg_c;
  logic                 s2_v;
  logic                 s2_wrap;

  nco_quarter_lut #(
    .LUT_WIDTH (LUT_WIDTH),
    .LUT_LENGTH(LUT_LENGTH)
  ) u_lut (
    .clk   (iclk),
    .reset (ireset),
    .en    (en),
    .addr_a(s1_a_sin),
    .addr_b(s1_a_cos),
    .data_a(mag_s),
    .data_b(mag_c)
  );

  always_ff @(posedge iclk) begin
    if (ireset) begin
      s2_neg_s <= 1'b0;
      s2_neg_c <= 1'b0;
      s2_v <= 1'b0;
      s2_wrap <= 1'b0;
    end else if (en) begin
      s2_neg_s <= s1_neg_s;
      s2_neg_c <= s1_neg_c;
      s2_v <= s1_v;
      s2_wrap <= s1_wrap;
    end
  end

  // Stage 3: apply sign; strobes drop while disabled.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      osin <= '0;
      ocos <= '0;
      ovalid <= 1'b0;
      owrap <= 1'b0;
    end else if (en) begin
      osin <= s2_neg_s ? -mag_s : mag_s;
      ocos <= s2_neg_c ? -mag_c : mag_c;
      ovalid <= s2_v;
      owrap <= s2_v & s2_wrap;
    end else begin
      ovalid <= 1'b0;
      owrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_nco_quadrature.sv
// tb_lut_nco_quadrature: scoreboard bench for lut_nco_quadrature.
// Reference samples come from real-valued sin/cos of the phase.
module tb_lut_nco_quadrature;
  import nco_pkg::*;

  logic                 iclk;
  logic                 ireset;
  logic                 inCS;
  logic [ACC_SIZE-1:0]  istep;
  logic                 istep_valid;
  logic                 imode;
  logic [PHASE_INT-1:0] ioffset;
  logic [15:0]          osin;
  logic [15:0]          ocos;
  logic                 ovalid;
  logic                 owrap;

  lut_nco_quadrature dut (
    .iclk       (iclk),
    .ireset     (ireset),
    .inCS       (inCS),
    .istep      (istep),
    .istep_valid(istep_valid),
    .imode      (imode),
    .ioffset    (ioffset),
    .osin       (osin),
    .ocos       (ocos),
    .ovalid     (ovalid),
    .owrap      (owrap)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    int s;
    int c;
    bit w;
  } samp_t;

  samp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  logic [ACC_SIZE-1:0] m_acc = '0;
  logic [ACC_SIZE-1:0] m_active = '0;
  logic [ACC_SIZE-1:0] m_pending = '0;
  bit m_accv = 0;
  bit m_wrap = 0;

  // Unit-step window statistics
  bit t3_on = 0;
  int t3_k = 0;
  int t3_wraps = 0;
  int t3_max = 0;
  int t3_min = 0;

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic samp_t ref_sample(int p, bit w);
    samp_t r;
    real th;
    th = 2.0 * 3.14159265358979 * (real'(p) + 0.5)
         / (2.0 ** PHASE_INT);
    r.s = rnd(32767.0 * $sin(th));
    r.c = rnd(32767.0 * $cos(th));
    r.w = w;
    return r;
  endfunction

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Inputs are set at the falling edge; the model consumes them
  // just after, before the rising edge the DUT samples them on.
  task automatic tick();
    logic [ACC_SIZE:0] s;
    logic [ACC_SIZE-1:0] oldp;
    logic [PHASE_INT-1:0] ph;
    bit en;
    #1;
    if (ireset) begin
      q.delete();
      m_acc = '0;
      m_active = '0;
      m_pending = '0;
      m_accv = 0;
      m_wrap = 0;
    end else begin
      en = !inCS;
      s = {1'b0, m_acc} + {1'b0, m_active};
      if (en) begin
        if (m_accv) begin
          ph = m_acc[ACC_SIZE-1 -: PHASE_INT] + ioffset;
          q.push_back(ref_sample(int'(ph), m_wrap));
        end
        m_acc = s[ACC_SIZE-1:0];
        m_wrap = s[ACC_SIZE];
        m_accv = 1;
      end
      oldp = m_pending;
      if (istep_valid)
        m_pending = istep;
      if (imode == NCO_MODE_AT_WRAP) begin
        if (en && s[ACC_SIZE])
          m_active = istep_valid ? istep : oldp;
      end else if (istep_valid) begin
        m_active = istep;
      end
    end
    @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic do_reset();
    ireset = 1;
    tick();
    tick();
    ireset = 0;
  endtask

  // Monitor: every valid output is matched against the queue head.
  always @(negedge iclk) begin
    samp_t e;
    if (ovalid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sample: unexpected output sin=%0d",
                 $signed(osin));
      end else begin
        e = q.pop_front();
        if (int'($signed(osin)) != e.s ||
            int'($signed(ocos)) != e.c || owrap != e.w) begin
          bad++;
          $display("FAIL sample: got sin=%0d cos=%0d wrap=%0b want sin=%0d cos=%0d wrap=%0b",
                   $signed(osin), $signed(ocos), owrap,
                   e.s, e.c, e.w);
        end
      end
      if (t3_on) begin
        if (t3_k >= 1 && t3_k <= 512) begin
          if (owrap) t3_wraps++;
          if (int'($signed(osin)) > t3_max)
            t3_max = int'($signed(osin));
          if (int'($signed(osin)) < t3_min)
            t3_min = int'($signed(osin));
        end
        t3_k++;
      end
    end
  end

  initial begin
    int n;
    int held;
    ireset = 1;
    inCS = 1;
    istep = '0;
    istep_valid = 0;
    imode = NCO_MODE_IMMEDIATE;
    ioffset = '0;
    @(negedge iclk);
    do_reset();
    chk("reset_sin", int'(osin), 0);
    chk("reset_cos", int'(ocos), 0);
    chk("reset_valid", int'(ovalid), 0);
    chk("reset_wrap", int'(owrap), 0);

    // First sample with zero step
    inCS = 0;
    istep_valid = 1;
    istep = '0;
    tick();
    istep_valid = 0;
    tick();
    tick();
    chk("first_valid_early", int'(ovalid), 0);
    tick();
    chk("first_valid", int'(ovalid), 1);
    chk("first_sin", int'($signed(osin)), 402);
    chk("first_cos", int'($signed(ocos)), 32765);
    repeat (5) tick();
    chk("const_valid", int'(ovalid), 1);
    chk("const_sin", int'($signed(osin)), 402);

    // Offset takes effect three cycles later
    ioffset = 8'd64;
    repeat (3) tick();
    chk("offset_sin", int'($signed(osin)), 32765);
    chk("offset_cos", int'($signed(ocos)), -402);
    ioffset = '0;

    // Quarter step
    do_reset();
    inCS = 0;
    istep = 16'd16384;
    istep_valid = 1;
    tick();
    istep_valid = 0;
    repeat (20) tick();

    // Unit step, full period statistics
    do_reset();
    inCS = 0;
    istep = 16'd256;
    istep_valid = 1;
    t3_on = 1;
    tick();
    istep_valid = 0;
    repeat (520) tick();
    t3_on = 0;
    chk("unit_wraps", t3_wraps, 2);
    chk("unit_peak_pos", t3_max, 32765);
    chk("unit_peak_neg", t3_min, -32765);

    // Freeze mid-run
    n = 0;
    held = int'($signed(osin));
    inCS = 1;
    repeat (5) begin
      tick();
      chk("freeze_valid", int'(ovalid), 0);
      chk("freeze_hold", int'($signed(osin)), held);
    end
    inCS = 0;
    repeat (10) tick();

    // Wrap-synchronised load at acc=0x4000
    imode = NCO_MODE_AT_WRAP;
    while (m_acc != 16'h4000 && n < 400) begin
      tick();
      n++;
    end
    chk("reach_4000", int'(m_acc), 16'h4000);
    istep = 16'd512;
    istep_valid = 1;
    tick();
    istep_valid = 0;
    repeat (300) tick();

    // All-ones step: reverse rotation, frequent wraps
    imode = NCO_MODE_IMMEDIATE;
    istep = 16'hFFFF;
    istep_valid = 1;
    tick();
    istep_valid = 0;
    repeat (40) tick();

    // Reset mid-run discards in-flight samples
    ireset = 1;
    tick();
    ireset = 0;
    chk("midreset_sin", int'(osin), 0);
    chk("midreset_cos", int'(ocos), 0);
    chk("midreset_valid", int'(ovalid), 0);

    // Randomised traffic
    repeat (3000) begin
      inCS = ($urandom_range(0, 7) == 0);
      istep_valid = ($urandom_range(0, 15) == 0);
      istep = 16'($urandom);
      imode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0)
        ioffset = 8'($urandom);
      ireset = ($urandom_range(0, 499) == 0);
      tick();
    end
    ireset = 0;
    inCS = 0;
    istep_valid = 0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
